// File: rtl/spi_periph_pkg.sv
// Shared types and constants for the SPI register peripheral: FSM states,
// R/W bit encoding and the frame-width helper.
package spi_periph_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_DONE
    } state_e;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int frame_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Brings the asynchronous SPI pins into the clk domain and derives
// single-cycle sclk rise/fall pulses from the synchronised clock.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic ncs,
    input  logic copi,
    output logic ncs_s,
    output logic copi_s,
    output logic sclk_rise,
    output logic sclk_fall
);

    logic [SYNC_STAGES-1:0] sclk_q, sclk_d;
    logic [SYNC_STAGES-1:0] ncs_q, ncs_d;
    logic [SYNC_STAGES-1:0] copi_q, copi_d;
    logic                   sclk_prev_q, sclk_prev_d;

    always_comb begin
        sclk_d      = {sclk_q[SYNC_STAGES-2:0], sclk};
        ncs_d       = {ncs_q[SYNC_STAGES-2:0], ncs};
        copi_d      = {copi_q[SYNC_STAGES-2:0], copi};
        sclk_prev_d = sclk_q[SYNC_STAGES-1];
    end

    // ncs resets deasserted so leaving reset never looks like a frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q      <= '0;
            ncs_q       <= '1;
            copi_q      <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_q      <= sclk_d;
            ncs_q       <= ncs_d;
            copi_q      <= copi_d;
            sclk_prev_q <= sclk_prev_d;
        end
    end

    assign ncs_s     = ncs_q[SYNC_STAGES-1];
    assign copi_s    = copi_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_prev_q;
    assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_prev_q;

endmodule

// File: rtl/spi_peripheral_rw.sv
// SPI mode-0 target with a read/write register file: frame is R/W bit,
// address, data (MSB first); reads shift the addressed register out on CIPO.
module spi_peripheral_rw
    import spi_periph_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       ncs,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);

    localparam int FRAME_W = frame_width(ADDR_W, DATA_W);
    localparam int CMD_W   = 1 + ADDR_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam int SH_W    = (CMD_W > DATA_W) ? CMD_W : DATA_W;

    logic ncs_s, copi_s, sclk_rise, sclk_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .ncs       (ncs),
        .copi      (copi),
        .ncs_s     (ncs_s),
        .copi_s    (copi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SH_W-2:0]     shin_q, shin_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   shout_q, shout_d;
    logic                cipo_q, cipo_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic                wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                frame_err_q, frame_err_d;
    logic [SH_W-1:0]     cur;

    // History plus the bit arriving this cycle; decoded only on the completing rise.
    assign cur = {shin_q, copi_s};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shin_d      = shin_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        shout_d     = shout_q;
        cipo_d      = cipo_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                cipo_d = 1'b0;
                if (!ncs_s) state_d = ST_CMD;
            end
            ST_CMD, ST_DATA: begin
                if (sclk_rise) begin
                    cnt_d  = cnt_q + 1'b1;
                    shin_d = cur[SH_W-2:0];
                end
                if (state_q == ST_DATA && sclk_fall && rw_q == RW_READ) begin
                    cipo_d  = shout_q[DATA_W-1];
                    shout_d = {shout_q[DATA_W-2:0], 1'b0};
                end
                // The count update is resolved before ncs, so a final rise
                // coinciding with ncs release still completes the frame.
                if (state_q == ST_CMD && cnt_d == CNT_W'(CMD_W)) begin
                    state_d = ST_DATA;
                    rw_d    = cur[ADDR_W];
                    addr_d  = cur[ADDR_W-1:0];
                    cipo_d  = 1'b0;
                    shout_d = '0;
                    for (int k = 0; k < NUM_REGS; k++) begin
                        if (cur[ADDR_W-1:0] == ADDR_W'(k)) shout_d = regs_q[k];
                    end
                end else if (state_q == ST_DATA && cnt_d == CNT_W'(FRAME_W)) begin
                    state_d = ST_DONE;
                    cipo_d  = 1'b0;
                    if (rw_q == RW_WRITE) begin
                        for (int k = 0; k < NUM_REGS; k++) begin
                            if (addr_q == ADDR_W'(k)) begin
                                regs_d[k]   = cur[DATA_W-1:0];
                                wr_strobe_d = 1'b1;
                                wr_addr_d   = addr_q;
                            end
                        end
                    end
                end else if (ncs_s) begin
                    state_d     = ST_IDLE;
                    frame_err_d = 1'b1;
                    cipo_d      = 1'b0;
                end
            end
            ST_DONE: begin
                cipo_d = 1'b0;
                if (ncs_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shin_q      <= '0;
            rw_q        <= RW_READ;
            addr_q      <= '0;
            shout_q     <= '0;
            cipo_q      <= 1'b0;
            regs_q      <= '{default: '0};
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shin_q      <= shin_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            shout_q     <= shout_d;
            cipo_q      <= cipo_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign regs_out[k*DATA_W +: DATA_W] = regs_q[k];
    end

    assign cipo_oe   = (state_q == ST_DATA) && (rw_q == RW_READ);
    assign cipo      = cipo_oe & cipo_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_peripheral_rw.sv
// Drives SPI frames at the pins and checks the peripheral against a
// register-array model of the frame rules.
module tb_spi_peripheral_rw;

    localparam int NUM_REGS = 5;
    localparam int ADDR_W   = 7;
    localparam int DATA_W   = 8;
    localparam int H        = 6;

    logic clk = 1'b0;
    logic rst, sclk, ncs, copi;
    logic cipo, cipo_oe, wr_strobe, frame_err;
    logic [NUM_REGS*DATA_W-1:0] regs_out;
    logic [ADDR_W-1:0] wr_addr;

    int asserts = 0;
    int fails   = 0;

    logic [DATA_W-1:0] exp_regs [NUM_REGS];
    logic [ADDR_W-1:0] exp_wr_addr;
    logic              check_en = 1'b0;
    int                strobe_cnt, err_cnt;
    logic [ADDR_W-1:0] last_wr_addr;
    logic [DATA_W-1:0] rd_bits;

    spi_peripheral_rw #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .ncs       (ncs),
        .copi      (copi),
        .cipo      (cipo),
        .cipo_oe   (cipo_oe),
        .regs_out  (regs_out),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
        logic [NUM_REGS*DATA_W-1:0] v;
        for (int k = 0; k < NUM_REGS; k++) v[k*DATA_W +: DATA_W] = exp_regs[k];
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        asserts++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Register file must match the model on every cycle outside commit windows.
    always @(negedge clk) begin
        if (check_en) begin
            asserts++;
            if (regs_out !== model_flat()) begin
                fails++;
                if (fails <= 20)
                    $display("FAIL regs_out: got %h expected %h", regs_out, model_flat());
            end
        end
        if (!rst) begin
            if (wr_strobe) begin
                strobe_cnt++;
                last_wr_addr = wr_addr;
            end
            if (frame_err) err_cnt++;
        end
    end

    // One frame of nrise sclk pulses; simul raises ncs together with the 16th rise.
    task automatic run_frame(input logic rw, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] data, input int nrise, input bit simul);
        logic [15:0]       frame;
        logic              complete, write_ok, exp_oe;
        logic [DATA_W-1:0] exp_rd;
        frame    = {rw, addr, data};
        complete = (nrise >= 16);
        write_ok = complete && rw && (addr < NUM_REGS);
        exp_rd   = (addr < NUM_REGS) ? exp_regs[addr] : '0;
        rd_bits  = '0;
        strobe_cnt = 0;
        err_cnt    = 0;
        ncs = 1'b0;
        wait_clk(H);
        for (int i = 0; i < nrise; i++) begin
            copi = (i < 16) ? frame[15-i] : 1'($urandom_range(0, 1));
            wait_clk(H);
            exp_oe = !rw && i >= 8 && i < 16;
            check("cipo_oe", cipo_oe, exp_oe);
            if (exp_oe) begin
                check("cipo_bit", cipo, exp_rd[15-i]);
                rd_bits[15-i] = cipo;
            end else begin
                check("cipo_idle", cipo, 1'b0);
            end
            if (i == 15) begin
                check_en = 1'b0;
                if (simul) ncs = 1'b1;
            end
            sclk = 1'b1;
            wait_clk(H);
            sclk = 1'b0;
        end
        wait_clk(H);
        ncs = 1'b1;
        wait_clk(2 * H);
        if (write_ok) begin
            exp_regs[addr] = data;
            exp_wr_addr    = addr;
        end
        check_en = 1'b1;
        check("strobe_count", 64'(strobe_cnt), write_ok ? 64'd1 : 64'd0);
        if (write_ok) check("strobe_addr", last_wr_addr, addr);
        check("frame_err_count", 64'(err_cnt), complete ? 64'd0 : 64'd1);
        check("wr_addr_hold", wr_addr, exp_wr_addr);
        check("cipo_oe_after", cipo_oe, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst_cipo", cipo, 1'b0);
        check("rst_cipo_oe", cipo_oe, 1'b0);
        check("rst_wr_strobe", wr_strobe, 1'b0);
        check("rst_wr_addr", wr_addr, 64'd0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_regs", regs_out, 64'd0);
    endtask

    initial begin
        logic [15:0] frame;
        int r, len;
        logic rw;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        bit simul;

        rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
        for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = '0;
        exp_wr_addr = '0;
        wait_clk(5);
        check_reset_outputs();
        rst = 1'b0;
        wait_clk(5);
        check_en = 1'b1;

        run_frame(1'b1, 7'h04, 8'hA5, 16, 1'b0);
        check("write_reg4_literal", regs_out[39:32], 8'hA5);
        check("write_addr_literal", wr_addr, 7'h04);

        run_frame(1'b1, 7'h01, 8'h3C, 16, 1'b0);
        run_frame(1'b0, 7'h01, 8'h00, 16, 1'b0);
        check("readback_literal", rd_bits, 8'h3C);
        check("reg1_after_read", regs_out[15:8], 8'h3C);

        run_frame(1'b1, 7'h05, 8'hFF, 16, 1'b0);
        run_frame(1'b0, 7'h7F, 8'h00, 16, 1'b0);
        check("read_oor_literal", rd_bits, 8'h00);

        run_frame(1'b1, 7'h00, 8'h22, 10, 1'b0);
        check("abort_reg0_literal", regs_out[7:0], 8'h00);
        run_frame(1'b1, 7'h00, 8'h11, 16, 1'b0);
        check("after_abort_literal", regs_out[7:0], 8'h11);

        run_frame(1'b1, 7'h02, 8'h5A, 20, 1'b0);
        check("overrun_reg2_literal", regs_out[23:16], 8'h5A);

        run_frame(1'b1, 7'h03, 8'h77, 16, 1'b1);
        check("simul_reg3_literal", regs_out[31:24], 8'h77);

        for (int n = 0; n < 40; n++) begin
            rw   = 1'($urandom_range(0, 1));
            r    = $urandom_range(0, 9);
            addr = (r < 8) ? ADDR_W'(r) : ADDR_W'($urandom_range(0, 127));
            data = DATA_W'($urandom_range(0, 255));
            r    = $urandom_range(0, 9);
            simul = 1'b0;
            if (r < 6)       len = 16;
            else if (r < 8)  len = $urandom_range(1, 15);
            else if (r == 8) len = $urandom_range(17, 22);
            else begin
                len = 16;
                simul = 1'b1;
            end
            run_frame(rw, addr, data, len, simul);
        end

        // Reset in the middle of a write to register 3.
        frame = {1'b1, 7'h03, 8'hC3};
        ncs = 1'b0;
        wait_clk(H);
        for (int i = 0; i < 12; i++) begin
            copi = frame[15-i];
            wait_clk(H);
            sclk = 1'b1;
            wait_clk(H);
            sclk = 1'b0;
        end
        check_en = 1'b0;
        rst = 1'b1;
        wait_clk(3);
        for (int k = 0; k < NUM_REGS; k++) exp_regs[k] = '0;
        exp_wr_addr = '0;
        check_reset_outputs();
        ncs = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(8);
        check_en = 1'b1;
        check("post_rst_regs_literal", regs_out, 64'd0);
        run_frame(1'b1, 7'h03, 8'h3E, 16, 1'b0);
        check("post_rst_write_literal", regs_out[31:24], 8'h3E);

        wait_clk(4);
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
